// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash controller.
// Each accepted request becomes one 0x03 READ transaction in SPI mode 0:
// 8 command bits, 24 address bits, then 32 data bits. The data bytes are
// returned little-endian, so the first byte from the flash is the low byte.
module spi_flash_reader #(
    parameter int CLK_DIV = 1,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic        flash_cs,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // The DONE cycle is the first chip-select-high cycle, so GAP covers CS_GAP-1 cycles.
    localparam int GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP - 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((CS_GAP > 2) ? (CS_GAP - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      tx_q, tx_d;
    logic [31:0]      rx_q, rx_d;
    logic [5:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             sck_q, sck_d;
    logic             cs_q;
    logic             busy_q;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;

    // Only word-aligned 24-bit flash addresses are reachable.
    logic unused_addr;
    assign unused_addr = ^{mem_addr[31:24], mem_addr[1:0]};

    assign mem_ready  = ready_q;
    assign mem_rdata  = rdata_q;
    assign busy       = busy_q;
    assign flash_cs   = cs_q;
    assign flash_clk  = sck_q;
    // TX is fully shifted out (all zeros) after slot 31, so MOSI idles at 0 during data.
    assign flash_mosi = tx_q[31];

    // Next-state, shift and handshake logic.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        sck_d   = sck_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                sck_d = 1'b0;
                if (mem_valid) begin
                    tx_d    = {8'h03, mem_addr[23:2], 2'b00};
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Falling SCK edge: sample MISO, advance MOSI, close the slot.
                        sck_d = 1'b0;
                        tx_d  = {tx_q[30:0], 1'b0};
                        if (bit_q[5]) begin
                            rx_d = {rx_q[30:0], flash_miso};
                        end
                        bit_d = bit_q + 6'd1;
                        if (bit_q == 6'd63) begin
                            state_d = S_DONE;
                            ready_d = 1'b1;
                            rdata_d = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                if (CS_GAP > 1) begin
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; outputs derive from the next state so all are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            sck_q   <= sck_d;
            cs_q    <= (state_d != S_SHIFT);
            busy_q  <= (state_d != S_IDLE);
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader: two instances (CLK_DIV 1 and 3) each
// talk to a behavioural SPI flash; expected words and ready cycles are pushed
// when a request is issued and popped by a monitor when mem_ready pulses.
module tb_spi_flash_reader;
    localparam int CS_GAP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done_flag [2];

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Flash contents: a fixed instruction at 0x100, pseudo-random bytes elsewhere.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        logic [31:0] h;
        case (a)
            24'h000100: return 8'h13;
            24'h000101: return 8'h05;
            24'h000102: return 8'h00;
            24'h000103: return 8'h00;
            default: begin
                h = 32'(a) * 32'h9E3779B1;
                return h[23:16] ^ h[31:24];
            end
        endcase
    endfunction

    // Word read from the flash at the aligned 24-bit address, little-endian.
    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [23:0] base;
        base = {addr[23:2], 2'b00};
        return {fbyte(base + 24'd3), fbyte(base + 24'd2), fbyte(base + 24'd1), fbyte(base)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = (g == 0) ? 1 : 3;

        logic        reset;
        logic        mem_valid;
        logic        mem_ready;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
        logic        busy;
        logic        flash_cs;
        logic        flash_clk;
        logic        flash_mosi;
        logic        flash_miso = 1'b0;

        spi_flash_reader #(.CLK_DIV(D), .CS_GAP(CS_GAP)) dut (
            .clk        (clk),
            .reset      (reset),
            .mem_valid  (mem_valid),
            .mem_ready  (mem_ready),
            .mem_addr   (mem_addr),
            .mem_rdata  (mem_rdata),
            .busy       (busy),
            .flash_cs   (flash_cs),
            .flash_clk  (flash_clk),
            .flash_mosi (flash_mosi),
            .flash_miso (flash_miso)
        );

        logic [31:0] exp_cmd_q [$];
        rsp_t        exp_rsp_q [$];
        int          next_ok   = 0;
        int          proto_bad = 0;

        // Behavioural flash: samples MOSI on SCK rise, drives MISO on SCK fall.
        int          rises = 0;
        logic [31:0] cmd_sh;
        logic [23:0] fbase;
        always @(posedge flash_cs or posedge flash_clk or negedge flash_clk) begin
            if (flash_cs === 1'b1) begin
                rises      = 0;
                flash_miso = 1'b0;
            end else if (flash_clk === 1'b1) begin
                if (rises < 32) cmd_sh = {cmd_sh[30:0], flash_mosi};
                rises++;
                if (rises == 32) begin
                    fbase = cmd_sh[23:0];
                    if (exp_cmd_q.size() == 0) check("cmd_unexpected", cmd_sh, 32'h0);
                    else check("cmd_addr", cmd_sh, exp_cmd_q.pop_front());
                end
            end else if (flash_clk === 1'b0) begin
                if (rises >= 32 && rises < 64) begin
                    int          idx;
                    logic [7:0]  b;
                    idx        = rises - 32;
                    b          = fbyte(fbase + 24'(idx / 8));
                    flash_miso = b[7 - (idx % 8)];
                end
            end
        end

        // Response monitor plus SPI waveform rules.
        logic prev_cs = 1'b1;
        logic prev_fclk = 1'b0;
        logic prev_mosi = 1'b0;
        int   run = 0;
        int   mosi_stable = 0;
        int   cs_hi_run = 0;
        always @(negedge clk) begin
            if (mem_ready === 1'b1) begin
                if (exp_rsp_q.size() == 0) begin
                    check("ready_unexpected", 32'(mem_ready), 32'h0);
                end else begin
                    rsp_t r;
                    r = exp_rsp_q.pop_front();
                    check("rdata", mem_rdata, r.data);
                    check("ready_cycle", cyc, r.cyc);
                end
            end
            if (flash_cs === 1'b0) begin
                if (busy !== 1'b1) proto_bad++;
                if (prev_cs) begin
                    if (cs_hi_run < CS_GAP) proto_bad++;
                    if (flash_clk !== 1'b0) proto_bad++;
                    run = 1;
                end else if (flash_clk !== prev_fclk) begin
                    if (run != D) proto_bad++;
                    if (flash_clk === 1'b1 && mosi_stable < D) proto_bad++;
                    run = 1;
                end else begin
                    run++;
                end
                if (flash_clk === 1'b1 && flash_mosi !== prev_mosi) proto_bad++;
                cs_hi_run = 0;
            end else begin
                if (flash_clk !== 1'b0) proto_bad++;
                cs_hi_run++;
            end
            mosi_stable = (flash_mosi !== prev_mosi) ? 1 : mosi_stable + 1;
            prev_cs     = (flash_cs !== 1'b0);
            prev_fclk   = flash_clk;
            prev_mosi   = flash_mosi;
        end

        // Raise a request and record what the flash and requester must see.
        task automatic issue(input logic [31:0] addr);
            int   acc;
            rsp_t r;
            mem_addr  = addr;
            mem_valid = 1'b1;
            acc       = (cyc > next_ok) ? cyc : next_ok;
            next_ok   = acc + 1 + 128 * D + CS_GAP;
            exp_cmd_q.push_back({8'h03, addr[23:2], 2'b00});
            r.data = ref_word(addr);
            r.cyc  = acc + 1 + 128 * D;
            exp_rsp_q.push_back(r);
        endtask

        // Wait for mem_ready; hold>0 drops mem_valid that many cycles in.
        task automatic wait_ready(input int hold);
            bit got;
            got = 1'b0;
            for (int n = 1; n <= 400 * D; n++) begin
                @(posedge clk);
                #1;
                if (hold > 0 && n == hold) mem_valid = 1'b0;
                if (mem_ready === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) check("ready_timeout", 32'(mem_ready), 32'h1);
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
        endtask

        task automatic check_reset_outputs(input string tag);
            check({tag, "_cs"}, 32'(flash_cs), 32'h1);
            check({tag, "_sck"}, 32'(flash_clk), 32'h0);
            check({tag, "_mosi"}, 32'(flash_mosi), 32'h0);
            check({tag, "_ready"}, 32'(mem_ready), 32'h0);
            check({tag, "_busy"}, 32'(busy), 32'h0);
            check({tag, "_rdata"}, mem_rdata, 32'h0);
        endtask

        initial begin
            reset     = 1'b1;
            mem_valid = 1'b0;
            mem_addr  = '0;
            repeat (3) @(posedge clk);
            #1;
            check_reset_outputs("por");
            reset = 1'b0;
            @(posedge clk);
            #1;
            next_ok = cyc;

            // Known instruction word, then the same word via an unaligned high address.
            issue(32'h0000_0100);
            wait_ready(0);
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check_reset_outputs("idle_rst");
            reset   = 1'b0;
            next_ok = cyc;
            issue(32'hFF00_0103);
            wait_ready(0);

            // Back-to-back: next request raised the cycle after mem_ready.
            issue(32'h0012_3454);
            wait_ready(0);
            issue(32'h00AB_CDEF);
            wait_ready(0);

            // mem_valid dropped early in the command phase.
            repeat (3) @(posedge clk);
            #1;
            issue(32'h0040_0010);
            wait_ready(5);

            // Randomised addresses, spacing and hold behaviour.
            for (int i = 0; i < 6; i++) begin
                logic [31:0] a;
                int          gap;
                int          hold;
                a    = $urandom();
                gap  = int'($urandom_range(0, 3));
                hold = (gap >= 2) ? int'($urandom_range(1, 60)) : 0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                issue(a);
                wait_ready(hold);
            end

            // Reset during the data phase (slot 40): no response, bus released.
            repeat (3) @(posedge clk);
            #1;
            issue(32'h0000_0200);
            for (int n = 0; n < 400 * D && rises < 41; n++) begin
                @(posedge clk);
                #1;
            end
            check("reached_slot40", 32'(rises >= 41), 32'h1);
            reset     = 1'b1;
            mem_valid = 1'b0;
            void'(exp_rsp_q.pop_back());
            @(posedge clk);
            #1;
            reset = 1'b0;
            check_reset_outputs("abort_rst");
            next_ok = cyc;
            repeat (150 * D) @(posedge clk);
            #1;
            issue(32'h0000_0100);
            wait_ready(0);

            for (int n = 0; n < 1000 && exp_rsp_q.size() > 0; n++) @(posedge clk);
            check("rsp_queue_drained", 32'(exp_rsp_q.size()), 32'h0);
            check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'h0);
            check("spi_protocol", 32'(proto_bad), 32'h0);
            done_flag[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(done_flag[0] && done_flag[1]); i++) @(posedge clk);
        check("all_done", 32'(done_flag[0] & done_flag[1]), 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
